// File: rtl/sc_io_device_if.sv
// Board-side and computer-side signal bundle for sc_io_device.
// The slave modport is the device; the master modport is the board/computer driving it.
interface sc_io_device_if;
    logic [9:0]  sw;
    logic [1:0]  key;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [31:0] out_port2;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic [31:0] in_port2;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;
    logic [6:0]  hex4;
    logic [6:0]  hex5;

    modport master (
        output sw, key, out_port0, out_port1, out_port2,
        input  in_port0, in_port1, in_port2,
        input  hex0, hex1, hex2, hex3, hex4, hex5
    );

    modport slave (
        input  sw, key, out_port0, out_port1, out_port2,
        output in_port0, in_port1, in_port2,
        output hex0, hex1, hex2, hex3, hex4, hex5
    );
endinterface

// File: rtl/sc_io_device.sv
// Board I/O: debounced switches/keys and a key press counter feed the computer's input ports;
// its three output ports are converted to two decimal digits each on the seven-segment displays.
module sc_io_device #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic           clock,
    input  logic           resetn,
    sc_io_device_if.slave  io
);

    localparam int unsigned CntW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);
    localparam logic [6:0] SegDash = 7'b0111111;
    localparam logic [6:0] SegZero = 7'b1000000;

    // ---------------------------------------------------------------------
    // Synchronizers and debouncers; bits [11:10] are the keys, [9:0] the switches.
    // ---------------------------------------------------------------------
    logic [11:0]           raw;
    logic [11:0]           sync1_q, sync2_q;
    logic [11:0]           stable_q, stable_d;
    logic [11:0][CntW-1:0] db_cnt_q, db_cnt_d;

    assign raw = {io.key, io.sw};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= {2'b11, 10'b0};
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 12; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == CntMax) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    logic [9:0] sw_stable;
    logic [1:0] key_stable;
    assign sw_stable  = stable_q[9:0];
    assign key_stable = stable_q[11:10];

    // ---------------------------------------------------------------------
    // Press counter and input ports
    // ---------------------------------------------------------------------
    logic       key0_prev_q;
    logic       key0_fall;
    logic [7:0] press_q, press_d;
    logic [31:0] in0_q, in1_q, in2_q;

    assign key0_fall = key0_prev_q & ~key_stable[0];

    // Clear has priority over a simultaneous press.
    always_comb begin
        press_d = press_q;
        if (!key_stable[1]) begin
            press_d = '0;
        end else if (key0_fall) begin
            press_d = press_q + 8'd1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key0_prev_q <= 1'b1;
            press_q     <= '0;
            in0_q       <= '0;
            in1_q       <= '0;
            in2_q       <= '0;
        end else begin
            key0_prev_q <= key_stable[0];
            press_q     <= press_d;
            in0_q       <= {27'b0, sw_stable[4:0]};
            in1_q       <= {27'b0, sw_stable[9:5]};
            in2_q       <= {24'b0, press_q};
        end
    end

    assign io.in_port0 = in0_q;
    assign io.in_port1 = in1_q;
    assign io.in_port2 = in2_q;

    // ---------------------------------------------------------------------
    // Shared binary-to-BCD converter, round-robin over the three output ports
    // ---------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StLoad, StShift, StStore} state_e;

    state_e      state_q, state_d;
    logic        load_en, shift_en, store_en;
    logic [1:0]  idx_q;
    logic [2:0]  bit_cnt_q;
    logic [14:0] shreg_q;
    logic [14:0] shreg_adj;
    logic        over_q;
    logic [31:0] sel;
    logic [2:0][3:0] tens_q, ones_q;
    logic [2:0]      ovf_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StLoad;
            StLoad:  state_d = StShift;
            StShift: if (bit_cnt_q == 3'd6) state_d = StStore;
            StStore: state_d = StLoad;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        load_en  = 1'b0;
        shift_en = 1'b0;
        store_en = 1'b0;
        unique case (state_q)
            StLoad:  load_en  = 1'b1;
            StShift: shift_en = 1'b1;
            StStore: store_en = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        unique case (idx_q)
            2'd0:    sel = io.out_port0;
            2'd1:    sel = io.out_port1;
            default: sel = io.out_port2;
        endcase
    end

    // shreg layout: {tens[3:0], ones[3:0], binary[6:0]}
    always_comb begin
        shreg_adj = shreg_q;
        if (shreg_q[10:7] >= 4'd5) shreg_adj[10:7] = shreg_q[10:7] + 4'd3;
        if (shreg_q[14:11] >= 4'd5) shreg_adj[14:11] = shreg_q[14:11] + 4'd3;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            idx_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            over_q    <= 1'b0;
            tens_q    <= '0;
            ones_q    <= '0;
            ovf_q     <= '0;
        end else begin
            if (load_en) begin
                shreg_q   <= {8'b0, sel[6:0]};
                over_q    <= (sel > 32'd99);
                bit_cnt_q <= '0;
            end
            if (shift_en) begin
                shreg_q   <= {shreg_adj[13:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (store_en) begin
                for (int p = 0; p < 3; p++) begin
                    if (idx_q == 2'(p)) begin
                        tens_q[p] <= shreg_q[14:11];
                        ones_q[p] <= shreg_q[10:7];
                        ovf_q[p]  <= over_q;
                    end
                end
                idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Seven-segment outputs
    // ---------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        unique case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [5:0][6:0] hex_q, hex_d;

    always_comb begin
        hex_d = hex_q;
        for (int p = 0; p < 3; p++) begin
            hex_d[2*p]   = ovf_q[p] ? SegDash : seg7(ones_q[p]);
            hex_d[2*p+1] = ovf_q[p] ? SegDash : seg7(tens_q[p]);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hex_q <= {6{SegZero}};
        end else begin
            hex_q <= hex_d;
        end
    end

    assign io.hex0 = hex_q[0];
    assign io.hex1 = hex_q[1];
    assign io.hex2 = hex_q[2];
    assign io.hex3 = hex_q[3];
    assign io.hex4 = hex_q[4];
    assign io.hex5 = hex_q[5];

endmodule

// File: tb/tb_sc_io_device.sv
// Directed bench for sc_io_device: debounce/press-counter vector table, press wrap,
// display conversion with over-range dashes, and reset during a conversion.
module tb_sc_io_device;

    logic clock;
    logic resetn;
    int   n_cmp;
    int   n_bad;

    sc_io_device_if io ();

    sc_io_device #(.DB_CYCLES(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .io     (io)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]  sw;
        logic [1:0]  key;
        int          hold;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // {tens, ones} segments for one port value
    function automatic logic [13:0] exp_pair(input logic [31:0] v);
        if (v > 32'd99) return {7'b0111111, 7'b0111111};
        return {seg(int'(v / 32'd10)), seg(int'(v % 32'd10))};
    endfunction

    task automatic wait_disp(input logic [31:0] v0, input logic [31:0] v1,
                             input logic [31:0] v2, input int budget, input string nm);
        logic [6:0]  e[6];
        logic [6:0]  a[6];
        logic [13:0] pr;
        bit          ok;
        pr = exp_pair(v0); e[1] = pr[13:7]; e[0] = pr[6:0];
        pr = exp_pair(v1); e[3] = pr[13:7]; e[2] = pr[6:0];
        pr = exp_pair(v2); e[5] = pr[13:7]; e[4] = pr[6:0];
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            a[0] = io.hex0; a[1] = io.hex1; a[2] = io.hex2;
            a[3] = io.hex3; a[4] = io.hex4; a[5] = io.hex5;
            ok = 1'b1;
            for (int k = 0; k < 6; k++) if (a[k] !== e[k]) ok = 1'b0;
            if (ok) break;
        end
        for (int k = 0; k < 6; k++)
            chk($sformatf("%s hex%0d", nm, k), {25'b0, a[k]}, {25'b0, e[k]});
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " in_port0"}, io.in_port0, 32'd0);
        chk({nm, " in_port1"}, io.in_port1, 32'd0);
        chk({nm, " in_port2"}, io.in_port2, 32'd0);
        chk({nm, " hex0"}, {25'b0, io.hex0}, {25'b0, 7'b1000000});
        chk({nm, " hex1"}, {25'b0, io.hex1}, {25'b0, 7'b1000000});
        chk({nm, " hex2"}, {25'b0, io.hex2}, {25'b0, 7'b1000000});
        chk({nm, " hex3"}, {25'b0, io.hex3}, {25'b0, 7'b1000000});
        chk({nm, " hex4"}, {25'b0, io.hex4}, {25'b0, 7'b1000000});
        chk({nm, " hex5"}, {25'b0, io.hex5}, {25'b0, 7'b1000000});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // sw, key, hold cycles, expected in_port0/1/2
        vecs.push_back('{10'b00011_00101, 2'b11, 10, 32'd5,  32'd3,  32'd0});
        vecs.push_back('{10'b00011_00100, 2'b11, 2,  32'd5,  32'd3,  32'd0}); // glitch on sw[0]
        vecs.push_back('{10'b00011_00101, 2'b11, 3,  32'd5,  32'd3,  32'd0});
        vecs.push_back('{10'b00011_00101, 2'b11, 5,  32'd5,  32'd3,  32'd0});
        vecs.push_back('{10'b11111_11111, 2'b11, 10, 32'd31, 32'd31, 32'd0});
        vecs.push_back('{10'b10101_01010, 2'b11, 10, 32'd10, 32'd21, 32'd0});
        vecs.push_back('{10'b10101_01010, 2'b10, 10, 32'd10, 32'd21, 32'd1});
        vecs.push_back('{10'b10101_01010, 2'b11, 10, 32'd10, 32'd21, 32'd1});
        vecs.push_back('{10'b10101_01010, 2'b10, 10, 32'd10, 32'd21, 32'd2});
        vecs.push_back('{10'b10101_01010, 2'b11, 10, 32'd10, 32'd21, 32'd2});
        vecs.push_back('{10'b10101_01010, 2'b10, 10, 32'd10, 32'd21, 32'd3});
        vecs.push_back('{10'b10101_01010, 2'b11, 10, 32'd10, 32'd21, 32'd3});
        vecs.push_back('{10'b10101_01010, 2'b01, 10, 32'd10, 32'd21, 32'd0}); // clear held
        vecs.push_back('{10'b10101_01010, 2'b11, 10, 32'd10, 32'd21, 32'd0});
        vecs.push_back('{10'b10101_01010, 2'b10, 10, 32'd10, 32'd21, 32'd1});
        vecs.push_back('{10'b10101_01010, 2'b11, 10, 32'd10, 32'd21, 32'd1});
        vecs.push_back('{10'b10101_01010, 2'b00, 10, 32'd10, 32'd21, 32'd0}); // press + clear
        vecs.push_back('{10'b10101_01010, 2'b11, 10, 32'd10, 32'd21, 32'd0});
        vecs.push_back('{10'b00000_00000, 2'b11, 10, 32'd0,  32'd0,  32'd0});

        resetn       = 1'b0;
        io.sw        = '0;
        io.key       = 2'b11;
        io.out_port0 = '0;
        io.out_port1 = '0;
        io.out_port2 = '0;
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        resetn = 1'b1;

        foreach (vecs[i]) begin
            io.sw  = vecs[i].sw;
            io.key = vecs[i].key;
            repeat (vecs[i].hold) @(negedge clock);
            chk($sformatf("vec%0d in_port0", i), io.in_port0, vecs[i].e0);
            chk($sformatf("vec%0d in_port1", i), io.in_port1, vecs[i].e1);
            chk($sformatf("vec%0d in_port2", i), io.in_port2, vecs[i].e2);
        end

        // Press counter wrap: 255 presses, then one more
        for (int n = 0; n < 256; n++) begin
            io.key = 2'b10;
            repeat (8) @(negedge clock);
            io.key = 2'b11;
            repeat (8) @(negedge clock);
            if (n == 254) chk("wrap 255 presses", io.in_port2, 32'd255);
        end
        chk("wrap 256 presses", io.in_port2, 32'd0);

        io.out_port0 = 32'd42;
        io.out_port1 = 32'd7;
        io.out_port2 = 32'd99;
        wait_disp(32'd42, 32'd7, 32'd99, 40, "disp 42/7/99");

        io.out_port1 = 32'd100;
        wait_disp(32'd42, 32'd100, 32'd99, 40, "disp over 100");
        io.out_port1 = 32'd5;
        wait_disp(32'd42, 32'd5, 32'd99, 40, "disp 5");
        io.out_port1 = 32'hFFFF_FFFF;
        wait_disp(32'd42, 32'hFFFF_FFFF, 32'd99, 40, "disp over max");

        // Reset, then hit reset again while the converter is in its shift phase
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);
        resetn = 1'b0;
        #1;
        chk_reset_outputs("mid-shift reset");
        @(negedge clock);
        resetn = 1'b1;
        wait_disp(32'd42, 32'hFFFF_FFFF, 32'd99, 40, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
